// File: rtl/pipe_stage_skid.sv
// Pipeline stage register between two adjacent stages (e.g. fetch->decode).
// Carries an instruction word and its PC over valid/ready handshakes on both
// sides. With SKID=1 a one-entry skid buffer lets in_ready be a flop while
// still sustaining one beat per cycle; with SKID=0 the stage is a single
// register whose in_ready is derived combinationally from out_ready.
// An empty stage presents a NOP bubble (NOP_INSTR / PC 0).

module pipe_stage_skid #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 10,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
    parameter bit                 SKID      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } stateT;

    stateT              state;
    stateT              nextState;

    logic [INSTR_W-1:0] mainInstr;
    logic [INSTR_W-1:0] nextMainInstr;
    logic [PC_W-1:0]    mainPc;
    logic [PC_W-1:0]    nextMainPc;
    logic [INSTR_W-1:0] skidInstr;
    logic [INSTR_W-1:0] nextSkidInstr;
    logic [PC_W-1:0]    skidPc;
    logic [PC_W-1:0]    nextSkidPc;

    logic               validReg;
    logic [1:0]         occReg;
    logic [1:0]         nextOcc;
    logic               readyReg;

    logic               acc;
    logic               emit;

    // Skid mode uses the flopped ready; single-register mode lets a stalled
    // full stage accept as soon as the consumer takes the current beat.
    assign in_ready  = SKID ? readyReg : (~validReg | out_ready);

    assign acc       = in_valid & in_ready;
    assign emit      = validReg & out_ready;

    assign out_valid = validReg;
    assign out_instr = mainInstr;
    assign out_pc    = mainPc;
    assign occ       = occReg;

    // Next-state and payload steering; flush overrides everything and drops
    // whatever is being accepted, the skid entry always drains into main.
    always_comb begin
        nextState     = state;
        nextMainInstr = mainInstr;
        nextMainPc    = mainPc;
        nextSkidInstr = skidInstr;
        nextSkidPc    = skidPc;

        if (flush) begin
            nextState     = EMPTY;
            nextMainInstr = NOP_INSTR;
            nextMainPc    = '0;
            nextSkidInstr = '0;
            nextSkidPc    = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        nextState     = FULL;
                        nextMainInstr = in_instr;
                        nextMainPc    = in_pc;
                    end
                end
                FULL: begin
                    if (acc && emit) begin
                        nextMainInstr = in_instr;
                        nextMainPc    = in_pc;
                    end else if (acc && SKID) begin
                        nextState     = SKIDF;
                        nextSkidInstr = in_instr;
                        nextSkidPc    = in_pc;
                    end else if (emit) begin
                        nextState     = EMPTY;
                        nextMainInstr = NOP_INSTR;
                        nextMainPc    = '0;
                    end
                end
                SKIDF: begin
                    if (emit) begin
                        nextState     = FULL;
                        nextMainInstr = skidInstr;
                        nextMainPc    = skidPc;
                        nextSkidInstr = '0;
                        nextSkidPc    = '0;
                    end
                end
                default: begin
                    nextState     = EMPTY;
                    nextMainInstr = NOP_INSTR;
                    nextMainPc    = '0;
                    nextSkidInstr = '0;
                    nextSkidPc    = '0;
                end
            endcase
        end
    end

    // Occupancy follows directly from the state being entered.
    always_comb begin
        case (nextState)
            EMPTY:   nextOcc = 2'd0;
            FULL:    nextOcc = 2'd1;
            SKIDF:   nextOcc = 2'd2;
            default: nextOcc = 2'd0;
        endcase
    end

    // State, payload and registered status outputs all move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            mainInstr <= NOP_INSTR;
            mainPc    <= '0;
            skidInstr <= '0;
            skidPc    <= '0;
            validReg  <= 1'b0;
            occReg    <= 2'd0;
            readyReg  <= 1'b1;
        end else begin
            state     <= nextState;
            mainInstr <= nextMainInstr;
            mainPc    <= nextMainPc;
            skidInstr <= nextSkidInstr;
            skidPc    <= nextSkidPc;
            validReg  <= (nextState != EMPTY);
            occReg    <= nextOcc;
            readyReg  <= (nextState != SKIDF);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance, each tracked
// by a queue model of the beats it holds, plus directed scenarios with literal
// expectations.

module tb_pipe_stage_skid;

    localparam int IW = 32;
    localparam int PW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          flush1    = 1'b0;
    logic          inValid1  = 1'b0;
    logic          inReady1;
    logic [IW-1:0] inInstr1  = '0;
    logic [PW-1:0] inPc1     = '0;
    logic          outValid1;
    logic          outReady1 = 1'b0;
    logic [IW-1:0] outInstr1;
    logic [PW-1:0] outPc1;
    logic [1:0]    occ1;

    logic          flush0    = 1'b0;
    logic          inValid0  = 1'b0;
    logic          inReady0;
    logic [IW-1:0] inInstr0  = '0;
    logic [PW-1:0] inPc0     = '0;
    logic          outValid0;
    logic          outReady0 = 1'b0;
    logic [IW-1:0] outInstr0;
    logic [PW-1:0] outPc0;
    logic [1:0]    occ0;

    int checks = 0;
    int fails  = 0;
    bit cmpEn  = 1'b0;

    logic [IW-1:0] streamI [3] = '{32'h11, 32'h22, 32'h33};
    logic [PW-1:0] streamP [3] = '{10'd4, 10'd8, 10'd12};

    always #5 clk = ~clk;

    pipe_stage_skid #(.INSTR_W(IW), .PC_W(PW), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(inValid1), .in_ready(inReady1), .in_instr(inInstr1), .in_pc(inPc1),
        .out_valid(outValid1), .out_ready(outReady1), .out_instr(outInstr1), .out_pc(outPc1),
        .occ(occ1)
    );

    pipe_stage_skid #(.INSTR_W(IW), .PC_W(PW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(inValid0), .in_ready(inReady0), .in_instr(inInstr0), .in_pc(inPc0),
        .out_valid(outValid0), .out_ready(outReady0), .out_instr(outInstr0), .out_pc(outPc0),
        .occ(occ0)
    );

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } beatT;

    beatT q1[$];
    beatT q0[$];
    bit   mAcc1, mEmit1, mAcc0, mEmit0;
    bit   lastAcc1 = 1'b0;
    bit   lastAcc0 = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of live beats; capacity 2 with skid, 1 without.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q0.delete();
            lastAcc1 = 1'b0;
            lastAcc0 = 1'b0;
        end else begin
            mAcc1  = inValid1 && (q1.size() < 2);
            mEmit1 = (q1.size() != 0) && outReady1;
            if (flush1) q1.delete();
            else begin
                if (mEmit1) void'(q1.pop_front());
                if (mAcc1) q1.push_back(beatT'{instr: inInstr1, pc: inPc1});
            end
            lastAcc1 = mAcc1;

            mAcc0  = inValid0 && ((q0.size() == 0) || outReady0);
            mEmit0 = (q0.size() != 0) && outReady0;
            if (flush0) q0.delete();
            else begin
                if (mEmit0) void'(q0.pop_front());
                if (mAcc0) q0.push_back(beatT'{instr: inInstr0, pc: inPc0});
            end
            lastAcc0 = mAcc0;
        end
    end

    // Every cycle, both instances must present exactly what the model holds.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cmp1 out_valid", 64'(outValid1), 64'(q1.size() != 0));
            checkOutput("cmp1 out_instr", 64'(outInstr1), (q1.size() != 0) ? 64'(q1[0].instr) : 64'd0);
            checkOutput("cmp1 out_pc",    64'(outPc1),    (q1.size() != 0) ? 64'(q1[0].pc)    : 64'd0);
            checkOutput("cmp1 occ",       64'(occ1),      64'(q1.size()));
            checkOutput("cmp1 in_ready",  64'(inReady1),  64'(q1.size() < 2));
            checkOutput("cmp0 out_valid", 64'(outValid0), 64'(q0.size() != 0));
            checkOutput("cmp0 out_instr", 64'(outInstr0), (q0.size() != 0) ? 64'(q0[0].instr) : 64'd0);
            checkOutput("cmp0 out_pc",    64'(outPc0),    (q0.size() != 0) ? 64'(q0[0].pc)    : 64'd0);
            checkOutput("cmp0 occ",       64'(occ0),      64'(q0.size()));
            checkOutput("cmp0 in_ready",  64'(inReady0),  64'((q0.size() == 0) || outReady0));
        end
    end

    // Random producer/consumer; a beat offered but not taken is held unchanged.
    task automatic applyStimulus();
        if (!inValid1 || lastAcc1) begin
            inValid1 = ($urandom_range(0, 9) < 7);
            inInstr1 = $urandom();
            inPc1    = PW'($urandom());
        end
        outReady1 = ($urandom_range(0, 9) < 6);
        flush1    = ($urandom_range(0, 39) == 0);
        if (!inValid0 || lastAcc0) begin
            inValid0 = ($urandom_range(0, 9) < 7);
            inInstr0 = $urandom();
            inPc0    = PW'($urandom());
        end
        outReady0 = ($urandom_range(0, 9) < 6);
        flush0    = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        cmpEn = 1'b1;
        #1;
        checkOutput("reset out_valid1", 64'(outValid1), 64'd0);
        checkOutput("reset out_instr1", 64'(outInstr1), 64'd0);
        checkOutput("reset out_pc1",    64'(outPc1),    64'd0);
        checkOutput("reset occ1",       64'(occ1),      64'd0);
        checkOutput("reset in_ready1",  64'(inReady1),  64'd1);
        checkOutput("reset in_ready0",  64'(inReady0),  64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] streaming through skid instance");
        outReady1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid1 = 1'b1;
            inInstr1 = streamI[i];
            inPc1    = streamP[i];
            step();
            checkOutput("stream out_valid", 64'(outValid1), 64'd1);
            checkOutput("stream out_instr", 64'(outInstr1), 64'(streamI[i]));
            checkOutput("stream out_pc",    64'(outPc1),    64'(streamP[i]));
            checkOutput("stream occ",       64'(occ1),      64'd1);
        end
        inValid1 = 1'b0;
        step();
        checkOutput("stream drained", 64'(outValid1), 64'd0);

        $display("[TB] single beat drain");
        inValid1 = 1'b1; inInstr1 = 32'h55; inPc1 = 10'd16;
        step();
        checkOutput("drain pulse valid", 64'(outValid1), 64'd1);
        checkOutput("drain pulse instr", 64'(outInstr1), 64'h55);
        inValid1 = 1'b0;
        step();
        checkOutput("drain bubble valid", 64'(outValid1), 64'd0);
        checkOutput("drain bubble instr", 64'(outInstr1), 64'd0);
        checkOutput("drain bubble pc",    64'(outPc1),    64'd0);

        $display("[TB] stall with skid fill");
        inValid1 = 1'b1; inInstr1 = 32'hAA; inPc1 = 10'd20; outReady1 = 1'b1;
        step();
        checkOutput("stall main instr", 64'(outInstr1), 64'hAA);
        inInstr1 = 32'hBB; inPc1 = 10'd24; outReady1 = 1'b0;
        step();
        checkOutput("stall occ2",      64'(occ1),      64'd2);
        checkOutput("stall in_ready",  64'(inReady1),  64'd0);
        checkOutput("stall hold1",     64'(outInstr1), 64'hAA);
        inInstr1 = 32'hCC; inPc1 = 10'd28;
        step();
        checkOutput("stall hold2",     64'(outInstr1), 64'hAA);
        step();
        checkOutput("stall hold3",     64'(outInstr1), 64'hAA);
        checkOutput("stall hold3 pc",  64'(outPc1),    64'd20);
        outReady1 = 1'b1;
        step();
        checkOutput("release BB",      64'(outInstr1), 64'hBB);
        checkOutput("release BB pc",   64'(outPc1),    64'd24);
        checkOutput("release occ",     64'(occ1),      64'd1);
        step();
        checkOutput("release CC",      64'(outInstr1), 64'hCC);
        inValid1 = 1'b0;
        step();
        checkOutput("release drained", 64'(outValid1), 64'd0);

        $display("[TB] flush while two entries held");
        inValid1 = 1'b1; inInstr1 = 32'h61; inPc1 = 10'd32; outReady1 = 1'b0;
        step();
        inInstr1 = 32'h62; inPc1 = 10'd36;
        step();
        checkOutput("preflush occ", 64'(occ1), 64'd2);
        inInstr1 = 32'h63; inPc1 = 10'd40; flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        checkOutput("flush out_valid", 64'(outValid1), 64'd0);
        checkOutput("flush out_instr", 64'(outInstr1), 64'd0);
        checkOutput("flush out_pc",    64'(outPc1),    64'd0);
        checkOutput("flush occ",       64'(occ1),      64'd0);
        checkOutput("flush in_ready",  64'(inReady1),  64'd1);
        inValid1 = 1'b0; outReady1 = 1'b1;
        step();
        step();
        checkOutput("flush stays empty", 64'(outValid1), 64'd0);

        $display("[TB] combinational ready instance");
        inValid0 = 1'b1; inInstr0 = 32'h71; inPc0 = 10'd44; outReady0 = 1'b0;
        step();
        checkOutput("nsk valid",     64'(outValid0), 64'd1);
        checkOutput("nsk instr",     64'(outInstr0), 64'h71);
        checkOutput("nsk in_ready0", 64'(inReady0),  64'd0);
        inInstr0 = 32'h72; inPc0 = 10'd48;
        step();
        checkOutput("nsk hold",      64'(outInstr0), 64'h71);
        outReady0 = 1'b1;
        #1;
        checkOutput("nsk comb ready", 64'(inReady0), 64'd1);
        step();
        checkOutput("nsk b2b 72",    64'(outInstr0), 64'h72);
        checkOutput("nsk b2b valid", 64'(outValid0), 64'd1);
        inInstr0 = 32'h73; inPc0 = 10'd52;
        step();
        checkOutput("nsk b2b 73",    64'(outInstr0), 64'h73);
        checkOutput("nsk b2b pc",    64'(outPc0),    64'd52);
        inValid0 = 1'b0;
        step();
        checkOutput("nsk drained",   64'(outValid0), 64'd0);

        $display("[TB] asynchronous reset with two entries held");
        inValid1 = 1'b1; inInstr1 = 32'h81; inPc1 = 10'd56; outReady1 = 1'b0;
        step();
        inInstr1 = 32'h82; inPc1 = 10'd60;
        step();
        checkOutput("prereset occ", 64'(occ1), 64'd2);
        #2 rst = 1'b1;
        inInstr1 = 32'h91; inPc1 = 10'd64; outReady1 = 1'b1;
        #1;
        checkOutput("async out_valid", 64'(outValid1), 64'd0);
        checkOutput("async out_instr", 64'(outInstr1), 64'd0);
        checkOutput("async out_pc",    64'(outPc1),    64'd0);
        checkOutput("async occ",       64'(occ1),      64'd0);
        checkOutput("async in_ready",  64'(inReady1),  64'd1);
        #2 rst = 1'b0;
        step();
        checkOutput("post reset accept", 64'(outInstr1), 64'h91);
        checkOutput("post reset pc",     64'(outPc1),    64'd64);
        inValid1 = 1'b0;
        step();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            step();
            if (n == 1500) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        inValid1 = 1'b0; inValid0 = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
        outReady1 = 1'b1; outReady0 = 1'b1;
        step();
        step();
        @(negedge clk);
        cmpEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
